// File: rtl/int_ctrl_pkg.sv
// int_ctrl shared types: line count, FSM states, lost-counter width,
// and the fixed priority order (lower line index wins).
package int_ctrl_pkg;

  localparam int NUM_INT = 2;
  localparam int ID_W    = 1;
  localparam int LOST_W  = 8;
  localparam int CNT_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  // Lowest eligible index wins: line 0 over line 1.
  function automatic logic [ID_W-1:0] pick_line(
    input logic [NUM_INT-1:0] elig
  );
    pick_line = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (elig[i]) pick_line = ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/int_sync.sv
// Per-line optional 2-flop synchronizer plus rising-edge detector.
// Ports: clk, rst (async high), line (raw level) -> rise (1-cycle pulse).
// Macro INT_SYNC_EN inserts the 2-flop synchronizer ahead of detection.
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic rise
);

  logic cur;
  logic cur_ok;
  logic low_seen;

`ifdef INT_SYNC_EN
  logic s1;
  logic s2;
  logic v1;
  logic v2;

  // v1/v2 mark when s2 holds a real sample rather than reset zeros,
  // so a line high through reset is not mistaken for a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      s1 <= line;
      s2 <= s1;
      v1 <= 1'b1;
      v2 <= v1;
    end
  end

  assign cur    = s2;
  assign cur_ok = v2;
`else
  assign cur    = line;
  assign cur_ok = 1'b1;
`endif

  // An edge needs a genuine low sample first; reset leaves it unarmed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_seen <= 1'b0;
    end else if (cur_ok) begin
      low_seen <= ~cur;
    end
  end

  assign rise = cur & low_seen;

endmodule

// File: rtl/int_ctrl.sv
// Two-line interrupt controller: edge latching, IDLE/REQ/SERV handshake,
// saturating dropped-edge counter. Ports: clk_gl, rst, interrupt,
// int_mask, int_en, int_ack, eret -> int_req, int_id, int_pending,
// int_busy, int_lost. Macro INT_SYNC_EN enables input synchronizers.
module int_ctrl
  import int_ctrl_pkg::*;
(
  input  logic               clk_gl,
  input  logic               rst,
  input  logic [NUM_INT-1:0] interrupt,
  input  logic [NUM_INT-1:0] int_mask,
  input  logic               int_en,
  input  logic               int_ack,
  input  logic               eret,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_INT-1:0] int_pending,
  output logic               int_busy,
  output logic [LOST_W-1:0]  int_lost
);

  logic [NUM_INT-1:0] rise;
  logic [NUM_INT-1:0] elig;
  logic [NUM_INT-1:0] clr;
  logic [NUM_INT-1:0] drop;
  logic [NUM_INT-1:0] pend_nx;
  logic [CNT_W-1:0]   drop_cnt;
  logic [LOST_W:0]    lost_sum;
  logic [LOST_W-1:0]  lost_nx;
  logic [ID_W-1:0]    id_nx;
  logic               take;
  state_t             state;
  state_t             state_nx;

  for (genvar g = 0; g < NUM_INT; g++) begin : g_line
    int_sync u_sync (
      .clk  (clk_gl),
      .rst  (rst),
      .line (interrupt[g]),
      .rise (rise[g])
    );
  end

  assign elig = int_pending & int_mask;

  always_comb begin
    state_nx = state;
    id_nx    = int_id;
    take     = 1'b0;
    unique case (state)
      IDLE: begin
        if (int_en && |elig) begin
          state_nx = REQ;
          id_nx    = pick_line(elig);
        end
      end
      REQ: begin
        // Withdrawal wins over a same-cycle ack: nothing is consumed.
        if (!int_en || !int_mask[int_id]) begin
          state_nx = IDLE;
        end else if (int_ack) begin
          state_nx = SERV;
          take     = 1'b1;
        end
      end
      SERV: begin
        if (eret) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A new edge on the line being acked re-sets its bit and is not a loss.
  always_comb begin
    clr      = '0;
    drop_cnt = '0;
    if (take) clr[int_id] = 1'b1;
    pend_nx = (int_pending & ~clr) | rise;
    drop    = rise & int_pending & ~clr;
    for (int i = 0; i < NUM_INT; i++) begin
      drop_cnt = drop_cnt + CNT_W'(drop[i]);
    end
    lost_sum = {1'b0, int_lost} + (LOST_W+1)'(drop_cnt);
    lost_nx  = lost_sum[LOST_W] ? '1 : lost_sum[LOST_W-1:0];
  end

  always_ff @(posedge clk_gl or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      int_id      <= '0;
      int_pending <= '0;
      int_lost    <= '0;
    end else begin
      state       <= state_nx;
      int_id      <= id_nx;
      int_pending <= pend_nx;
      int_lost    <= lost_nx;
    end
  end

  assign int_req  = (state == REQ);
  assign int_busy = (state == SERV);

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus random
// stimulus against an in-bench behavioural model of edges/pending/FSM.
module tb_int_ctrl;

`ifdef INT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_SERV = 2;

  logic       clk_gl = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] interrupt = 2'b00;
  logic [1:0] int_mask = 2'b11;
  logic       int_en = 1'b1;
  logic       int_ack = 1'b0;
  logic       eret = 1'b0;
  logic       int_req;
  logic       int_id;
  logic [1:0] int_pending;
  logic       int_busy;
  logic [7:0] int_lost;

  int checks = 0;
  int errors = 0;

  int         m_t;
  logic [1:0] m_hist [0:3];
  logic [1:0] m_pend;
  int         m_lost;
  int         m_phase;
  int         m_id;

  int_ctrl dut (
    .clk_gl      (clk_gl),
    .rst         (rst),
    .interrupt   (interrupt),
    .int_mask    (int_mask),
    .int_en      (int_en),
    .int_ack     (int_ack),
    .eret        (eret),
    .int_req     (int_req),
    .int_id      (int_id),
    .int_pending (int_pending),
    .int_busy    (int_busy),
    .int_lost    (int_lost)
  );

  always #5 clk_gl = ~clk_gl;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic void model_reset();
    m_t     = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 2'b00;
    m_pend  = 2'b00;
    m_lost  = 0;
    m_phase = P_IDLE;
    m_id    = 0;
  endfunction

  // One clock edge of the reference: line samples are a history indexed
  // by edges since reset; an edge is a 0->1 step between two valid
  // effective samples, where "effective" is LAT edges old.
  function automatic void model_step();
    logic [1:0] now_v;
    logic [1:0] prev_v;
    logic [1:0] newp;
    logic [1:0] elig;
    bit         now_ok;
    bit         prev_ok;
    bit         take;
    m_t++;
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = interrupt;
    now_v   = m_hist[LAT];
    prev_v  = m_hist[LAT+1];
    now_ok  = (m_t - LAT) >= 1;
    prev_ok = (m_t - LAT - 1) >= 1;
    take = (m_phase == P_REQ) && int_en && int_mask[m_id] && int_ack;
    newp = m_pend;
    for (int i = 0; i < 2; i++) begin
      bit rise_i;
      bit clr_i;
      rise_i = now_ok && prev_ok && now_v[i] && !prev_v[i];
      clr_i  = take && (m_id == i);
      if (rise_i) begin
        if (m_pend[i] && !clr_i && m_lost < 255) m_lost++;
        newp[i] = 1'b1;
      end else if (clr_i) begin
        newp[i] = 1'b0;
      end
    end
    elig = m_pend & int_mask;
    case (m_phase)
      P_IDLE: if (int_en && elig != 2'b00) begin
        m_phase = P_REQ;
        m_id    = elig[0] ? 0 : 1;
      end
      P_REQ: begin
        if (!int_en || !int_mask[m_id]) m_phase = P_IDLE;
        else if (int_ack) m_phase = P_SERV;
      end
      default: if (eret) m_phase = P_IDLE;
    endcase
    m_pend = newp;
  endfunction

  task automatic compare_all();
    check("req", int_req, m_phase == P_REQ);
    check("busy", int_busy, m_phase == P_SERV);
    check("pending", int_pending, m_pend);
    check("lost", int_lost, m_lost);
    if (m_phase != P_IDLE) check("id", int_id, m_id);
  endtask

  task automatic cycle();
    @(posedge clk_gl);
    model_step();
    @(negedge clk_gl);
    compare_all();
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    cycle();
    int_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1;
    cycle();
    eret = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (m_phase != P_REQ && n < 12) begin
      cycle();
      n++;
    end
    check("wait_req", int_req, 1);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_req", int_req, 0);
    check("rst_busy", int_busy, 0);
    check("rst_pend", int_pending, 0);
    check("rst_lost", int_lost, 0);
    check("rst_id", int_id, 0);
    model_reset();
    @(posedge clk_gl);
    @(negedge clk_gl);
    check("rst_hold_req", int_req, 0);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk_gl);
    do_reset();
    repeat (4) cycle();

    // Single line 1 edge: latency, service and return.
    interrupt = 2'b10;
    for (int c = 0; c <= LAT + 1; c++) begin
      cycle();
      if (c == LAT - 1) check("a_pend_early", int_pending, 0);
      if (c == LAT) check("a_pend", int_pending, 2);
      if (c == LAT) check("a_req_early", int_req, 0);
      if (c == LAT + 1) check("a_req", int_req, 1);
      if (c == LAT + 1) check("a_id", int_id, 1);
    end
    pulse_ack();
    check("a_busy", int_busy, 1);
    check("a_pend_clr", int_pending, 0);
    pulse_eret();
    check("a_idle", int_busy, 0);
    interrupt = 2'b00;
    repeat (4) cycle();

    // Both lines together: line 0 first, then line 1.
    interrupt = 2'b11;
    wait_req();
    check("b_pend", int_pending, 3);
    check("b_id0", int_id, 0);
    pulse_ack();
    check("b_pend_after", int_pending, 2);
    pulse_eret();
    wait_req();
    check("b_id1", int_id, 1);
    pulse_ack();
    pulse_eret();
    interrupt = 2'b00;
    repeat (4) cycle();

    // Masked line still latches, unmasking raises the request.
    int_mask  = 2'b01;
    interrupt = 2'b10;
    repeat (LAT + 4) cycle();
    check("c_req_masked", int_req, 0);
    check("c_pend", int_pending, 2);
    int_mask = 2'b11;
    cycle();
    check("c_req", int_req, 1);

    // Global enable withdrawal and return.
    int_en = 1'b0;
    cycle();
    check("d_req_off", int_req, 0);
    check("d_pend", int_pending, 2);
    int_en = 1'b1;
    cycle();
    check("d_req_back", int_req, 1);
    check("d_id", int_id, 1);
    pulse_ack();
    pulse_eret();
    interrupt = 2'b00;
    repeat (4) cycle();

    // Lost-edge counting while line 0 waits in service.
    interrupt = 2'b01;
    wait_req();
    pulse_ack();
    for (int k = 0; k < 3; k++) begin
      interrupt[0] = 1'b0;
      cycle();
      interrupt[0] = 1'b1;
      cycle();
    end
    repeat (LAT + 1) cycle();
    check("e_lost2", int_lost, 2);
    check("e_busy", int_busy, 1);
    for (int k = 0; k < 300; k++) begin
      interrupt[0] = 1'b0;
      cycle();
      interrupt[0] = 1'b1;
      cycle();
    end
    repeat (LAT + 1) cycle();
    check("e_lost_sat", int_lost, 255);
    pulse_eret();
    wait_req();

    // Reset mid-REQ with line held high through release.
    do_reset();
    repeat (8) cycle();
    check("f_no_req", int_req, 0);
    check("f_no_pend", int_pending, 0);
    interrupt = 2'b00;
    cycle();
    interrupt = 2'b01;
    wait_req();
    check("f_rearm_id", int_id, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) interrupt[i] = ~interrupt[i];
      end
      if ($urandom_range(0, 15) == 0) int_mask = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) int_en = ~int_en;
      int_ack = ($urandom_range(0, 2) == 0);
      eret    = ($urandom_range(0, 3) == 0);
      cycle();
    end
    int_ack = 1'b0;
    eret    = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have port clk_gl, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port interrupt, input, 2 bits: external level interrupt lines, asynchronous to clk_gl.
REQ-004 The block SHALL have port int_mask, input, 2 bits: per-line enable from CP0 status IM field.
REQ-005 The block SHALL have port int_en, input, 1 bit: global interrupt enable (CP0 IE).
REQ-006 The block SHALL have port int_ack, input, 1 bit: pipeline accepted the request; single-cycle pulse.
REQ-007 The block SHALL have port eret, input, 1 bit: pipeline retired ERET; single-cycle pulse.
REQ-008 The block SHALL have port int_req, output, 1 bit: interrupt request to the pipeline.
REQ-009 The block SHALL have port int_id, output, 1 bit: index of the requested/in-service line.
REQ-010 The block SHALL have port int_pending, output, 2 bits: latched pending bits.
REQ-011 The block SHALL have port int_busy, output, 1 bit: handler in service.
REQ-012 The block SHALL have port int_lost, output, 8 bits: saturating count of dropped edges.

Function
REQ-013 A rising edge on a line SHALL set its int_pending bit; masked lines SHALL still latch pending.
REQ-014 The FSM SHALL have states IDLE, REQ and SERV; int_req = (state==REQ); int_busy = (state==SERV).
REQ-015 IDLE->REQ SHALL occur when int_en=1 and (int_pending & int_mask)!=0.
REQ-016 On entry to REQ, int_id SHALL latch the highest-priority eligible line (line 0 over line 1) and hold it stable until leaving REQ.
REQ-017 REQ->SERV SHALL occur on int_ack=1; the same edge SHALL clear int_pending[int_id], unless a new edge on that line arrives in the same cycle, in which case the bit stays set.
REQ-018 REQ->IDLE SHALL occur if int_en=0 or the latched line becomes masked before int_ack; pending bits SHALL be kept.
REQ-019 SERV->IDLE SHALL occur on eret=1; no nesting: pending lines wait in SERV.
REQ-020 int_ack outside REQ and eret outside SERV SHALL be ignored.
REQ-021 An edge on a line whose pending bit is already set SHALL increment int_lost, saturating at 8'hFF.
REQ-022 Simultaneous edges on both lines SHALL set both pending bits in the same cycle.
REQ-023 Level held high SHALL produce exactly one pending event; re-arm requires the line to go low.

Reset
REQ-024 On rst=1, immediately and regardless of clock, state SHALL be IDLE; int_req, int_id, int_pending, int_busy, int_lost and all synchronizer/edge registers SHALL be 0.
REQ-025 Reset asserted in REQ or SERV SHALL drop int_req/int_busy without waiting for handshake; a line high at reset release SHALL NOT count as an edge until it goes low and high again.

Configuration
REQ-026 With INT_SYNC_EN defined, each line SHALL pass a 2-flop synchronizer before edge detection; interrupt first sampled high at edge k gives int_pending at k+2 and int_req at k+3.
REQ-027 Without INT_SYNC_EN, edge detection SHALL use the raw input; int_pending at k, int_req at k+1.

Structure
REQ-028 Package int_ctrl_pkg SHALL hold NUM_INT=2, the state typedef (IDLE/REQ/SERV), LOST_W=8 and the priority order.
REQ-029 Sub-module int_sync SHALL implement per-line optional synchronizer plus rising-edge detector, instantiated NUM_INT times.

Verification
REQ-030 interrupt=2'b10, mask=2'b11, int_en=1, with INT_SYNC_EN -> int_pending=2'b10 at k+2, int_req=1 with int_id=1 at k+3; int_ack pulse -> int_busy=1, pending=2'b00; eret -> IDLE.
REQ-031 Both lines rise same cycle -> pending=2'b11, int_id=0 first; after ack and eret, second request with int_id=1.
REQ-032 Line 1 edge, int_mask=2'b01 -> pending=2'b10, int_req stays 0; set mask=2'b11 -> int_req next cycle.
REQ-033 int_req high, int_en drops to 0 -> int_req 0 next cycle, pending unchanged; int_en back to 1 -> int_req again with same int_id.
REQ-034 Three edges on line 0 while held pending in SERV -> int_lost=2; 300 such edges -> int_lost=8'hFF.
REQ-035 rst pulsed mid-REQ between clock edges -> int_req=0 immediately; all outputs 0; line held high through reset produces no request.
